// File: rtl/fetch_sequencer.sv
// Instruction-fetch control sequencer: drives bus-source and load enables
// for T0-T2, handshaking with memory and the execute sequencer.
module fetch_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             exec_done,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             IRin,
    output logic             fetch_done,
    output logic             fetch_error,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_HANDOFF,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              error_q, error_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        count_d    = count_q;
        error_d    = error_q;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        fetch_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                wait_d  = '0;
                state_d = S_T1W;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = mem_ready;
                // ready on the last permitted wait cycle still completes
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                count_d = count_q + CNT_W'(1);
                state_d = S_HANDOFF;
            end
            S_HANDOFF: begin
                fetch_done = 1'b1;
                if (exec_done) state_d = run ? S_T0 : S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fetch_error = error_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (default and small parameters)
// share stimulus; checked by vector table, directed sequences and a model.
module tb_fetch_sequencer;

    logic clock = 1'b0;
    logic reset, run, mem_ready, exec_done;

    always #5 clock = ~clock;

    logic b_pc, b_zl, b_mdro, b_mar, b_inc, b_zin, b_pcin;
    logic b_rd, b_mdri, b_ir, b_done, b_err;
    logic [15:0] b_cnt;
    logic s_pc, s_zl, s_mdro, s_mar, s_inc, s_zin, s_pcin;
    logic s_rd, s_mdri, s_ir, s_done, s_err;
    logic [1:0] s_cnt;
    logic [11:0] b_ctl, s_ctl;

    assign b_ctl = {b_pc, b_zl, b_mdro, b_mar, b_inc, b_zin,
                    b_pcin, b_rd, b_mdri, b_ir, b_done, b_err};
    assign s_ctl = {s_pc, s_zl, s_mdro, s_mar, s_inc, s_zin,
                    s_pcin, s_rd, s_mdri, s_ir, s_done, s_err};

    fetch_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) u_big (
        .clock(clock), .reset(reset), .run(run),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .PCout(b_pc), .Zlowout(b_zl), .MDRout(b_mdro),
        .MARin(b_mar), .IncPC(b_inc), .Zin(b_zin),
        .PCin(b_pcin), .Read(b_rd), .MDRin(b_mdri),
        .IRin(b_ir), .fetch_done(b_done),
        .fetch_error(b_err), .fetch_count(b_cnt)
    );

    fetch_sequencer #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
        .clock(clock), .reset(reset), .run(run),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .PCout(s_pc), .Zlowout(s_zl), .MDRout(s_mdro),
        .MARin(s_mar), .IncPC(s_inc), .Zin(s_zin),
        .PCin(s_pcin), .Read(s_rd), .MDRin(s_mdri),
        .IRin(s_ir), .fetch_done(s_done),
        .fetch_error(s_err), .fetch_count(s_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: position within a fetch (-1 idle, 0..4 = T0,T1,
    // wait,T2,handoff, 5 = timed out), cycles waited, fetches completed.
    int  m_pos[2];
    int  m_wait[2];
    int  m_cnt[2];
    int  tmo[2] = '{16, 4};
    int  modv[2] = '{65536, 4};
    bit  m_valid = 1'b0;

    function automatic logic [11:0] exp_ctl(input int pos, input bit rdy);
        case (pos)
            0:       return 12'h9C0;
            1:       return 12'h430;
            2:       return rdy ? 12'h018 : 12'h010;
            3:       return 12'h204;
            4:       return 12'h002;
            5:       return 12'h001;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pos[i]  = -1;
                m_wait[i] = 0;
                m_cnt[i]  = 0;
            end else begin
                case (m_pos[i])
                    -1: if (run) m_pos[i] = 0;
                    0: m_pos[i] = 1;
                    1: begin m_pos[i] = 2; m_wait[i] = 0; end
                    2: begin
                        if (mem_ready) m_pos[i] = 3;
                        else if (m_wait[i] + 1 >= tmo[i]) m_pos[i] = 5;
                        else m_wait[i]++;
                    end
                    3: begin
                        m_pos[i] = 4;
                        m_cnt[i] = (m_cnt[i] + 1) % modv[i];
                    end
                    4: if (exec_done) m_pos[i] = run ? 0 : -1;
                    default: m_pos[i] = m_pos[i];
                endcase
            end
        end
        if (reset) m_valid = 1'b1;
    endtask

    task automatic apply(input bit r, input bit ru, input bit rd,
                         input bit ex);
        reset = r; run = ru; mem_ready = rd; exec_done = ex;
        #1;
        if (m_valid) begin
            chk("big_ctl_model", b_ctl, exp_ctl(m_pos[0], rd));
            chk("big_cnt_model", b_cnt, m_cnt[0]);
            chk("small_ctl_model", s_ctl, exp_ctl(m_pos[1], rd));
            chk("small_cnt_model", s_cnt, m_cnt[1]);
            chk("big_bus_excl", 32'($countones({b_pc, b_zl, b_mdro}) <= 1), 1);
            chk("small_bus_excl", 32'($countones({s_pc, s_zl, s_mdro}) <= 1), 1);
            chk("big_mdrin_read", 32'(!b_mdri || b_rd), 1);
            chk("small_mdrin_read", 32'(!s_mdri || s_rd), 1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          ru;
        bit          rd;
        bit          ex;
        logic [11:0] ctl;
        int          cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 12'h000, 0};
        tbl[1]  = '{0, 1, 1, 0, 12'h000, 0};
        tbl[2]  = '{0, 0, 1, 0, 12'h9C0, 0};
        tbl[3]  = '{0, 0, 1, 0, 12'h430, 0};
        tbl[4]  = '{0, 0, 1, 0, 12'h018, 0};
        tbl[5]  = '{0, 0, 1, 0, 12'h204, 0};
        tbl[6]  = '{0, 0, 1, 0, 12'h002, 1};
        tbl[7]  = '{0, 1, 0, 1, 12'h002, 1};
        tbl[8]  = '{0, 0, 0, 0, 12'h9C0, 1};
        tbl[9]  = '{0, 0, 0, 0, 12'h430, 1};
        tbl[10] = '{0, 0, 0, 0, 12'h010, 1};
        tbl[11] = '{0, 0, 0, 0, 12'h010, 1};
        tbl[12] = '{0, 0, 0, 0, 12'h010, 1};
        tbl[13] = '{0, 0, 1, 0, 12'h018, 1};
        tbl[14] = '{0, 0, 0, 0, 12'h204, 1};
        tbl[15] = '{0, 0, 0, 1, 12'h002, 2};
        tbl[16] = '{0, 0, 0, 0, 12'h000, 2};
        tbl[17] = '{0, 0, 1, 1, 12'h000, 2};

        // reset held two cycles, then idle with run low
        apply(1, 0, 0, 0); tick();
        apply(1, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0);
            chk("idle_ctl", b_ctl, 12'h000);
            chk("idle_cnt", b_cnt, 0);
            tick();
        end

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].r, tbl[i].ru, tbl[i].rd, tbl[i].ex);
            chk($sformatf("vec%0d_ctl", i), b_ctl, tbl[i].ctl);
            chk($sformatf("vec%0d_cnt", i), b_cnt, tbl[i].cnt);
            tick();
        end

        // memory timeout: small times out after 4 waits, big after 16
        apply(1, 0, 0, 0); tick();
        apply(1, 0, 0, 0); tick();
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, 0, 0); tick();
        end
        apply(0, 0, 0, 0);
        chk("small_timeout", s_ctl, 12'h001);
        chk("big_still_wait", b_ctl, 12'h010);
        for (int i = 0; i < 14; i++) begin
            apply(0, i[0], 0, 1); tick();
        end
        apply(0, 1, 1, 1);
        chk("big_timeout", b_ctl, 12'h001);
        chk("small_sticky", s_ctl, 12'h001);
        tick();
        apply(1, 0, 0, 0); tick();
        apply(0, 0, 0, 0);
        chk("err_clr_big", b_ctl, 12'h000);
        chk("err_clr_small", s_ctl, 12'h000);

        // reset while waiting in T1W after one completed fetch
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 1, 0); tick();
        end
        apply(0, 1, 0, 0);
        chk("pre_rst_cnt", b_cnt, 1);
        chk("pre_rst_done", b_ctl, 12'h002);
        apply(0, 1, 0, 1); tick();
        apply(0, 1, 0, 0); tick();
        apply(0, 1, 0, 0); tick();
        apply(0, 1, 0, 0);
        chk("t1w_read", b_ctl, 12'h010);
        apply(1, 1, 0, 0); tick();
        apply(0, 0, 0, 0);
        chk("rst_t1w_ctl", b_ctl, 12'h000);
        chk("rst_t1w_cnt", b_cnt, 0);
        tick();

        // 2-bit counter wraps 1,2,3,0
        for (int k = 0; k < 4; k++) begin
            bit found = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                apply(0, 1, 1, 1);
                if (s_done) begin
                    found = 1'b1;
                    chk("wrap_cnt", s_cnt, (k + 1) % 4);
                end
                tick();
            end
            if (!found) chk("wrap_wait", 0, 1);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
